// File: rtl/rv_cpu.sv
// rv_cpu: single-cycle RV32I-subset core. One instruction is fetched from a
// combinational ROM and fully executed per clock. The register file and PC
// update on the rising edge, and a store is committed to the external RAM on
// that same edge.
// Build option: define CPU_MUL_EN to execute MUL (low 32 bits of rs1*rs2).
// Without it, that encoding behaves as a NOP.
module rv_cpu #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic [31:0] readData,
   output logic [31:0] result,
   output logic [31:0] instrAddr,
   output logic [31:0] dataAddr,
   output logic [31:0] writeData,
   output logic        we
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   logic [31:0] pc_q, pc_d;
   logic [31:0] rf_q [32];

   logic [6:0]  opcode, funct7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] rs1_v, rs2_v, pc_plus4, mem_addr, wb_data;
   logic [31:0] alu_res;
   logic        rd_wen, wb_from_mem, st_en, br_take;

   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign funct3 = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign funct7 = instr[31:25];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   // x0 is hard-wired to zero; same-cycle writes are not forwarded (old value read)
   assign rs1_v = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
   assign rs2_v = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

   assign pc_plus4 = pc_q + 32'd4;
   // Shared adder: load/store address, and also the JALR target (I-immediate)
   assign mem_addr = rs1_v + ((opcode == OP_STORE) ? imm_s : imm_i);
   assign wb_data  = wb_from_mem ? readData : alu_res;

   assign instrAddr = pc_q;
   assign dataAddr  = mem_addr;
   assign writeData = rs2_v;
   assign result    = alu_res;
   assign we        = st_en & ~reset;

   // Decode and execute: ALU result, write-back control, store enable, next PC
   always_comb begin
      alu_res     = 32'd0;
      rd_wen      = 1'b0;
      wb_from_mem = 1'b0;
      st_en       = 1'b0;
      br_take     = 1'b0;
      pc_d        = pc_plus4;
      case (opcode)
         OP_LUI: begin
            alu_res = imm_u;
            rd_wen  = 1'b1;
         end
         OP_AUIPC: begin
            alu_res = pc_q + imm_u;
            rd_wen  = 1'b1;
         end
         OP_JAL: begin
            alu_res = pc_plus4;
            rd_wen  = 1'b1;
            pc_d    = pc_q + imm_j;
         end
         OP_JALR: begin
            if (funct3 == 3'b000) begin
               alu_res = pc_plus4;
               rd_wen  = 1'b1;
               pc_d    = {mem_addr[31:1], 1'b0};
            end
         end
         OP_BRANCH: begin
            case (funct3)
               3'b000:  br_take = (rs1_v == rs2_v);
               3'b001:  br_take = (rs1_v != rs2_v);
               3'b100:  br_take = ($signed(rs1_v) <  $signed(rs2_v));
               3'b101:  br_take = ($signed(rs1_v) >= $signed(rs2_v));
               3'b110:  br_take = (rs1_v <  rs2_v);
               3'b111:  br_take = (rs1_v >= rs2_v);
               default: br_take = 1'b0;
            endcase
            alu_res = {31'd0, br_take};
            if (br_take) pc_d = pc_q + imm_b;
         end
         OP_LOAD: begin
            if (funct3 == 3'b010) begin
               alu_res     = mem_addr;
               rd_wen      = 1'b1;
               wb_from_mem = 1'b1;
            end
         end
         OP_STORE: begin
            if (funct3 == 3'b010) begin
               alu_res = mem_addr;
               st_en   = 1'b1;
            end
         end
         OP_IMM: begin
            rd_wen = 1'b1;
            case (funct3)
               3'b000: alu_res = rs1_v + imm_i;
               3'b010: alu_res = {31'd0, $signed(rs1_v) < $signed(imm_i)};
               3'b011: alu_res = {31'd0, rs1_v < imm_i};
               3'b100: alu_res = rs1_v ^ imm_i;
               3'b110: alu_res = rs1_v | imm_i;
               3'b111: alu_res = rs1_v & imm_i;
               3'b001: begin
                  if (funct7 == 7'b0000000) alu_res = rs1_v << rs2;
                  else rd_wen = 1'b0;
               end
               3'b101: begin
                  if (funct7 == 7'b0000000) alu_res = rs1_v >> rs2;
                  else if (funct7 == 7'b0100000) alu_res = $signed(rs1_v) >>> rs2;
                  else rd_wen = 1'b0;
               end
               default: rd_wen = 1'b0;
            endcase
         end
         OP_REG: begin
            rd_wen = 1'b1;
            case (funct7)
               7'b0000000: begin
                  case (funct3)
                     3'b000:  alu_res = rs1_v + rs2_v;
                     3'b001:  alu_res = rs1_v << rs2_v[4:0];
                     3'b010:  alu_res = {31'd0, $signed(rs1_v) < $signed(rs2_v)};
                     3'b011:  alu_res = {31'd0, rs1_v < rs2_v};
                     3'b100:  alu_res = rs1_v ^ rs2_v;
                     3'b101:  alu_res = rs1_v >> rs2_v[4:0];
                     3'b110:  alu_res = rs1_v | rs2_v;
                     default: alu_res = rs1_v & rs2_v;
                  endcase
               end
               7'b0100000: begin
                  if (funct3 == 3'b000) alu_res = rs1_v - rs2_v;
                  else if (funct3 == 3'b101) alu_res = $signed(rs1_v) >>> rs2_v[4:0];
                  else rd_wen = 1'b0;
               end
`ifdef CPU_MUL_EN
               7'b0000001: begin
                  if (funct3 == 3'b000) alu_res = rs1_v * rs2_v;
                  else rd_wen = 1'b0;
               end
`endif
               default: rd_wen = 1'b0;
            endcase
         end
         default: ;
      endcase
   end

   // PC and register-file update; reset clears PC to RESET_PC and all registers
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= RESET_PC;
         for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
      end else begin
         pc_q <= pc_d;
         if (rd_wen && (rd != 5'd0)) rf_q[rd] <= wb_data;
      end
   end

endmodule

// File: tb/tb_rv_cpu.sv
// tb_rv_cpu: bench for rv_cpu with a ROM/RAM model around the core, a
// directed vector table, hand-written reset/loop sequences and a randomized
// instruction stream checked against an instruction-level reference model.
module tb_rv_cpu;

   logic        clk, reset;
   logic [31:0] instr, readData, result, instrAddr, dataAddr, writeData;
   logic        we;

   logic [31:0] rom [256];
   logic [31:0] ram [256];

   int npass = 0;
   int ntot  = 0;

   rv_cpu #(.RESET_PC(32'h0)) dut (
      .clk(clk), .reset(reset), .instr(instr), .readData(readData),
      .result(result), .instrAddr(instrAddr), .dataAddr(dataAddr),
      .writeData(writeData), .we(we)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb instr = rom[instrAddr[9:2]];
   always_comb readData = ram[dataAddr[9:2]];
   always @(posedge clk) if (we) ram[dataAddr[9:2]] <= writeData;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

`ifdef CPU_MUL_EN
   localparam logic [31:0] MULX = 32'h0000_3F01;
`else
   localparam logic [31:0] MULX = 32'h0000_0000;
`endif

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h expected %h", n, act, exp);
   endtask

   // ---------------- instruction encoders ----------------
   function automatic logic [31:0] e_i(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [2:0] f3, input logic [4:0] rs1, input int imm);
      logic [31:0] m;
      m = imm;
      return {m[11:0], rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
      return {f7, rs2, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] e_s(input int imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [2:0] f3);
      logic [31:0] m;
      m = imm;
      return {m[11:5], rs2, rs1, f3, m[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] e_b(input int imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [2:0] f3);
      logic [31:0] m;
      m = imm;
      return {m[12], m[10:5], rs2, rs1, f3, m[4:1], m[11], 7'h63};
   endfunction

   function automatic logic [31:0] e_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
      return {imm, rd, op};
   endfunction

   function automatic logic [31:0] e_j(input int imm, input logic [4:0] rd);
      logic [31:0] m;
      m = imm;
      return {m[20], m[10:1], m[11], m[19:12], rd, 7'h6F};
   endfunction

   // ---------------- reference model ----------------
   logic [31:0] mr [32];
   logic [31:0] mpc;
   logic [31:0] mmem [256];

   function automatic logic [31:0] sx(input logic [31:0] v, input int b);
      logic signed [31:0] t;
      t = v << (32 - b);
      return t >>> (32 - b);
   endfunction

   task automatic model_step(input logic [31:0] ins, output logic cres, output logic [31:0] eres,
                             output logic ewe, output logic caddr, output logic [31:0] eaddr,
                             output logic [31:0] ewd);
      logic [6:0]  op, f7;
      logic [4:0]  rd, r1, r2;
      logic [2:0]  f3;
      logic [31:0] a, b, iI, iS, iB, iU, iJ, npc, val;
      logic        wr, t;
      op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12];
      r1 = ins[19:15]; r2 = ins[24:20]; f7 = ins[31:25];
      a = mr[r1]; b = mr[r2];
      iI = sx({20'd0, ins[31:20]}, 12);
      iS = sx({20'd0, ins[31:25], ins[11:7]}, 12);
      iB = sx({19'd0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
      iU = {ins[31:12], 12'd0};
      iJ = sx({11'd0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
      npc = mpc + 4; val = 0; wr = 0; t = 0;
      cres = 0; eres = 0; ewe = 0; caddr = 0; eaddr = 0; ewd = 0;
      case (op)
         7'h37: begin val = iU; wr = 1; end
         7'h17: begin val = mpc + iU; wr = 1; end
         7'h6F: begin val = mpc + 4; wr = 1; npc = mpc + iJ; end
         7'h67: if (f3 == 0) begin val = mpc + 4; wr = 1; npc = (a + iI) & ~32'd1; end
         7'h63: begin
            case (f3)
               0: t = (a == b);
               1: t = (a != b);
               4: t = $signed(a) <  $signed(b);
               5: t = $signed(a) >= $signed(b);
               6: t = a <  b;
               7: t = a >= b;
               default: t = 0;
            endcase
            if (t) npc = mpc + iB;
         end
         7'h03: if (f3 == 2) begin
            eaddr = a + iI; caddr = 1; cres = 1; eres = eaddr;
            val = mmem[eaddr[9:2]]; wr = 1;
         end
         7'h23: if (f3 == 2) begin
            eaddr = a + iS; caddr = 1; cres = 1; eres = eaddr;
            ewe = 1; ewd = b;
            mmem[eaddr[9:2]] = b;
         end
         7'h13: begin
            wr = 1;
            case (f3)
               0: val = a + iI;
               2: val = ($signed(a) < $signed(iI)) ? 1 : 0;
               3: val = (a < iI) ? 1 : 0;
               4: val = a ^ iI;
               6: val = a | iI;
               7: val = a & iI;
               1: if (f7 == 0) val = a << r2; else wr = 0;
               default: begin
                  if (f7 == 0) val = a >> r2;
                  else if (f7 == 7'h20) val = $signed(a) >>> r2;
                  else wr = 0;
               end
            endcase
         end
         7'h33: begin
            wr = 1;
            if (f7 == 0) begin
               case (f3)
                  0: val = a + b;
                  1: val = a << b[4:0];
                  2: val = ($signed(a) < $signed(b)) ? 1 : 0;
                  3: val = (a < b) ? 1 : 0;
                  4: val = a ^ b;
                  5: val = a >> b[4:0];
                  6: val = a | b;
                  default: val = a & b;
               endcase
            end else if (f7 == 7'h20 && f3 == 0) val = a - b;
            else if (f7 == 7'h20 && f3 == 5) val = $signed(a) >>> b[4:0];
`ifdef CPU_MUL_EN
            else if (f7 == 7'h01 && f3 == 0) val = a * b;
`endif
            else wr = 0;
         end
         default: ;
      endcase
      if (wr && op != 7'h03 && op != 7'h6F && op != 7'h67) begin cres = 1; eres = val; end
      if (wr && rd != 0) mr[rd] = val;
      mpc = npc;
   endtask

   function automatic logic [31:0] rnd_ins();
      logic [4:0]  rd, r1, r2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] u;
      int          imm;
      rd = 5'($urandom_range(0, 7));
      r1 = 5'($urandom_range(0, 7));
      r2 = 5'($urandom_range(0, 7));
      f3 = 3'($urandom_range(0, 7));
      u  = $urandom;
      imm = int'(u);
      case ($urandom_range(0, 11))
         0, 1, 2: begin
            if ((f3 == 1 || f3 == 5) && $urandom_range(0, 3) != 0)
               imm = int'({20'd0, ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, u[4:0]});
            return e_i(7'h13, rd, f3, r1, imm);
         end
         3, 4: begin
            case ($urandom_range(0, 3))
               0, 1:    f7 = 7'h00;
               2:       f7 = 7'h20;
               default: f7 = ($urandom_range(0, 1) != 0) ? 7'h01 : u[31:25];
            endcase
            return e_r(f7, r2, r1, f3, rd, 7'h33);
         end
         5:  return e_u(u[31:12], rd, ($urandom_range(0, 1) != 0) ? 7'h37 : 7'h17);
         6:  return e_b(int'($urandom_range(0, 32)) * 4 - 64, r2, r1, f3);
         7:  return e_j(int'($urandom_range(0, 64)) * 4 - 128, rd);
         8:  return e_i(7'h67, rd, ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd0, r1, imm);
         9:  return e_i(7'h03, rd, ($urandom_range(0, 3) == 0) ? f3 : 3'd2, r1, imm);
         10: return e_s(imm, r2, r1, ($urandom_range(0, 3) == 0) ? f3 : 3'd2);
         default: return u;
      endcase
   endfunction

   // ---------------- directed vector table ----------------
   typedef struct {
      string       name;
      logic [31:0] ins;
      logic        chk_res;
      logic [31:0] res;
      logic [31:0] npc;
      logic        we;
      logic [31:0] wd;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input string n, input logic [31:0] ins, input logic c, input logic [31:0] res,
                      input logic [31:0] npc, input logic w = 1'b0, input logic [31:0] wd = 32'd0);
      vec_t v;
      v.name = n; v.ins = ins; v.chk_res = c; v.res = res; v.npc = npc; v.we = w; v.wd = wd;
      tbl.push_back(v);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      logic [31:0] cur, ins, eres, eaddr, ewd;
      logic        cres, ewe, caddr;
      int          cyc;

      reset = 1'b1;
      for (int i = 0; i < 256; i++) rom[i] = 32'h0000_0013;

      // ---- reset: store in ROM slot 0 must not write while reset is held ----
      rom[0] = e_s(0, 1, 0, 2);
      @(negedge clk);
      @(negedge clk);
      chk("rst_pc", instrAddr, 32'h0);
      chk("rst_we", {31'd0, we}, 32'd0);
      rom[0] = 32'h0000_0013;
      reset = 1'b0;
      chk("rel_pc0", instrAddr, 32'h0);
      @(negedge clk);
      chk("rel_pc4", instrAddr, 32'h4);
      @(negedge clk);
      chk("rel_pc8", instrAddr, 32'h8);

      // ---- count loop: 255 iterations, store count, spin on JAL x0,0 ----
      rom[0] = e_i(7'h13, 1, 0, 0, 0);
      rom[1] = e_i(7'h13, 2, 0, 0, 255);
      rom[2] = e_b(16, 0, 2, 0);
      rom[3] = e_i(7'h13, 1, 0, 1, 1);
      rom[4] = e_i(7'h13, 2, 0, 2, -1);
      rom[5] = e_j(-12, 0);
      rom[6] = e_s(0, 1, 0, 2);
      rom[7] = e_j(0, 0);
      do_reset();
      cyc = 0;
      while (instrAddr !== 32'h1C && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      chk("loop_reach", instrAddr, 32'h1C);
      repeat (3) @(negedge clk);
      chk("loop_hold", instrAddr, 32'h1C);
      chk("loop_ram0", ram[0], 32'h0000_00FF);

      // ---- directed table ----
      add("addi_neg", e_i(7'h13, 1, 0, 0, -1), 1, 32'hFFFF_FFFF, 32'h04);
      add("bltu_tk",  e_b(8, 1, 0, 6), 0, 0, 32'h0C);
      add("blt_nt",   e_b(8, 1, 0, 4), 0, 0, 32'h10);
      add("srai",     e_i(7'h13, 2, 5, 1, 'h404), 1, 32'hFFFF_FFFF, 32'h14);
      add("srli",     e_i(7'h13, 2, 5, 1, 4), 1, 32'h0FFF_FFFF, 32'h18);
      add("sltiu",    e_i(7'h13, 3, 3, 0, 1), 1, 32'h1, 32'h1C);
      add("addi_x0",  e_i(7'h13, 0, 0, 0, 5), 1, 32'h5, 32'h20);
      add("add_x0",   e_r(0, 0, 0, 0, 3, 7'h33), 1, 32'h0, 32'h24);
      add("addi_7f",  e_i(7'h13, 5, 0, 0, 'h7F), 1, 32'h7F, 32'h28);
      add("sw",       e_s(8, 5, 0, 2), 1, 32'h8, 32'h2C, 1'b1, 32'h7F);
      add("lw",       e_i(7'h03, 6, 2, 0, 8), 1, 32'h8, 32'h30);
      add("add_ld",   e_r(0, 0, 6, 0, 7, 7'h33), 1, 32'h7F, 32'h34);
      add("addi_40",  e_i(7'h13, 2, 0, 0, 'h40), 1, 32'h40, 32'h38);
      add("jalr",     e_i(7'h67, 1, 0, 2, 3), 0, 0, 32'h42);
      add("link",     e_r(0, 0, 1, 0, 8, 7'h33), 1, 32'h3C, 32'h46);
      add("lui",      e_u(20'h12345, 4, 7'h37), 1, 32'h1234_5000, 32'h4A);
      add("jal_back", e_j(-12, 0), 0, 0, 32'h3E);
      add("auipc",    e_u(20'h1, 13, 7'h17), 1, 32'h103E, 32'h42);
      add("beq_back", e_b(-8, 0, 0, 0), 0, 0, 32'h3A);
      add("bgeu_nt",  e_b(16, 1, 0, 7), 0, 0, 32'h3E);
      add("bne_tk",   e_b(16, 0, 1, 1), 0, 0, 32'h4E);
      add("bge_tk",   e_b(-64, 0, 1, 5), 0, 0, 32'h0E);
      add("sub",      e_r(7'h20, 1, 0, 0, 9, 7'h33), 1, 32'hFFFF_FFC4, 32'h12);
      add("slt",      e_r(0, 0, 9, 2, 10, 7'h33), 1, 32'h1, 32'h16);
      add("sltu",     e_r(0, 0, 9, 3, 10, 7'h33), 1, 32'h0, 32'h1A);
      add("sra",      e_r(7'h20, 8, 9, 5, 11, 7'h33), 1, 32'hFFFF_FFFF, 32'h1E);
      add("sll",      e_r(0, 8, 5, 1, 11, 7'h33), 1, 32'hF000_0000, 32'h22);
      add("xori",     e_i(7'h13, 12, 4, 5, 'hF0), 1, 32'h8F, 32'h26);
      add("ori",      e_i(7'h13, 12, 6, 5, 'h100), 1, 32'h17F, 32'h2A);
      add("andi",     e_i(7'h13, 12, 7, 9, -16), 1, 32'hFFFF_FFC0, 32'h2E);
      add("slti",     e_i(7'h13, 12, 2, 9, -100), 1, 32'h0, 32'h32);
      add("lb_nop",   e_i(7'h03, 14, 0, 0, 8), 0, 0, 32'h36);
      add("sb_nop",   e_s(0, 5, 0, 0), 0, 0, 32'h3A);
      add("lb_noreg", e_r(0, 0, 14, 0, 15, 7'h33), 1, 32'h0, 32'h3E);
      add("mul",      e_r(7'h01, 5, 5, 0, 16, 7'h33), 0, 0, 32'h42);
      add("mul_reg",  e_r(0, 0, 16, 0, 17, 7'h33), 1, MULX, 32'h46);
      add("mulh_nop", e_r(7'h01, 5, 5, 1, 18, 7'h33), 0, 0, 32'h4A);
      add("mulh_reg", e_r(0, 0, 18, 0, 19, 7'h33), 1, 32'h0, 32'h4E);
      add("or",       e_r(0, 9, 5, 6, 20, 7'h33), 1, 32'hFFFF_FFFF, 32'h52);
      add("and",      e_r(0, 9, 5, 7, 20, 7'h33), 1, 32'h44, 32'h56);
      add("srl",      e_r(0, 8, 9, 5, 21, 7'h33), 1, 32'hF, 32'h5A);
      add("slli31",   e_i(7'h13, 21, 1, 5, 31), 1, 32'h8000_0000, 32'h5E);
      add("addi_m4",  e_i(7'h13, 22, 0, 0, -4), 1, 32'hFFFF_FFFC, 32'h62);
      add("jalr_top", e_i(7'h67, 0, 0, 22, 0), 0, 0, 32'hFFFF_FFFC);
      add("pc_wrap",  e_i(7'h13, 23, 0, 0, 1), 1, 32'h1, 32'h0);
      add("jal_self", e_j(0, 0), 0, 0, 32'h0);
      add("jal_hold", e_j(0, 0), 0, 0, 32'h0);

      do_reset();
      cur = 32'h0;
      foreach (tbl[k]) begin
         rom[cur[9:2]] = tbl[k].ins;
         #1;
         chk({tbl[k].name, "_pc"}, instrAddr, cur);
         if (tbl[k].chk_res) chk(tbl[k].name, result, tbl[k].res);
         chk({tbl[k].name, "_we"}, {31'd0, we}, {31'd0, tbl[k].we});
         if (tbl[k].we) begin
            chk({tbl[k].name, "_wd"}, writeData, tbl[k].wd);
            chk({tbl[k].name, "_addr"}, dataAddr, tbl[k].res);
         end
         @(negedge clk);
         cur = tbl[k].npc;
      end
      chk("tbl_end_pc", instrAddr, cur);

      // ---- randomized stream against the reference model ----
      do_reset();
      for (int i = 0; i < 32; i++) mr[i] = 32'd0;
      for (int i = 0; i < 256; i++) mmem[i] = ram[i];
      mpc = 32'h0;
      for (int i = 0; i < 3000; i++) begin
         ins = rnd_ins();
         rom[mpc[9:2]] = ins;
         #1;
         chk("r_pc", instrAddr, mpc);
         model_step(ins, cres, eres, ewe, caddr, eaddr, ewd);
         chk("r_we", {31'd0, we}, {31'd0, ewe});
         if (cres) chk("r_res", result, eres);
         if (caddr) chk("r_addr", dataAddr, eaddr);
         if (ewe) chk("r_wd", writeData, ewd);
         @(negedge clk);
      end
      chk("r_end_pc", instrAddr, mpc);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
